mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
Parameters: none; all widths fixed.
REQ-001 CLK  input  1  single clock; all state updates on posedge CLK.
REQ-002 Reset  input  1  reset, asynchronous and active-low (0 = reset).
REQ-003 req_valid  input  1  CPU request present.
REQ-004 req_ready  output  1  controller can accept a request.
REQ-005 req_we  input  1  1 = store, 0 = load.
REQ-006 req_size  input  2  00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 req_signed  input  1  loads only: 1 = sign-extend, 0 = zero-extend.
REQ-008 req_addr  input  8  byte address.
REQ-009 req_wdata  input  32  store data, right-justified for byte and halfword.
REQ-010 rsp_valid  output  1  one-cycle completion pulse.
REQ-011 rsp_rdata  output  32  load result, extended to 32 bits.
REQ-012 rsp_err  output  1  request rejected: misaligned or illegal size.
REQ-013 Mem_Addr  output  8  to data memory: word-aligned byte address.
REQ-014 Mem_Read  output  1  to data memory: read strobe.
REQ-015 Mem_Write  output  1  to data memory: write strobe.
REQ-016 M_W_Data  output  32  to data memory: little-endian write word.
REQ-017 M_R_Data  input  32  from data memory: registered read word, valid the cycle after a Mem_Read cycle.

Function
REQ-018 The FSM SHALL have states IDLE, RD, CAP, WR and RESP; req_ready = 1 only in IDLE.
REQ-019 On the edge where req_valid && req_ready, the request SHALL be latched and the address aligned to {addr[7:2],2'b00}; later input changes SHALL have no effect.
REQ-020 A request SHALL be an error when size = 11, or size = 01 with addr[0] = 1, or size = 10 with addr[1:0] != 0.
REQ-021 For an error request, the FSM SHALL go IDLE->RESP, assert rsp_err = 1 and leave both memory strobes low for the whole transaction.
REQ-022 Word store path SHALL be IDLE->WR->RESP, with M_W_Data = req_wdata during WR.
REQ-023 Load path SHALL be IDLE->RD->CAP->RESP.
REQ-024 Byte/halfword store path SHALL be IDLE->RD->CAP->WR->RESP (read-modify-write).
REQ-025 Mem_Read SHALL be 1 only in RD and Mem_Write SHALL be 1 only in WR; both are decoded from the state register and are never high together.
REQ-026 Mem_Addr SHALL carry the latched aligned address in RD and WR, and 0 otherwise.
REQ-027 In CAP, byte lane addr[1:0] (byte k = bits 8k+7:8k) or half lane addr[1] SHALL be selected from M_R_Data.
  - Loads: the lane is extended per req_signed into rsp_rdata.
  - Stores: the low bytes of req_wdata replace that lane in a merge register; all other lanes are kept.
REQ-028 In WR of a sub-word store, M_W_Data SHALL equal the merge register.
REQ-029 RESP SHALL last exactly one cycle with rsp_valid = 1 and then return to IDLE; there is no backpressure.
REQ-030 rsp_rdata SHALL be 0 for stores and errors; rsp_err SHALL be 0 for non-error requests.
REQ-031 Latency from the accept edge to rsp_valid high SHALL be: error 1 cycle, word store 2, load 3, sub-word store 4.
REQ-032 rsp_rdata and rsp_err SHALL be held stable from RESP until the next accept.

Reset
REQ-033 While Reset = 0, the controller SHALL immediately force state IDLE and drive these outputs:
  - req_ready = 1;
  - rsp_valid = 0, rsp_err = 0, rsp_rdata = 0;
  - Mem_Read = 0, Mem_Write = 0, Mem_Addr = 0, M_W_Data = 0.
REQ-034 Reset asserted in any state before the WR edge SHALL abort the transaction with no memory write and no rsp_valid.
REQ-035 The first request SHALL be accepted on the first posedge CLK with Reset = 1 and req_valid = 1.

Verification
REQ-036 Store word 0xDEADBEEF at 0x10, then load word 0x10 -> Mem_Write pulses once; rsp_valid 2 cycles after accept for the store and 3 cycles after for the load; load rsp_rdata = 0xDEADBEEF.
REQ-037 After REQ-036, store byte 0xAA at 0x11 -> RD, CAP, WR sequence with M_W_Data = 0xDEADAAEF; signed byte load 0x11 -> 0xFFFFFFAA; unsigned byte load 0x11 -> 0x000000AA.
REQ-038 Signed halfword load 0x12 -> 0xFFFFDEAD; unsigned -> 0x0000DEAD; halfword load 0x13 -> rsp_err = 1 one cycle after accept, no strobes.
REQ-039 req_size = 11 store at 0x20 -> rsp_err = 1, Mem_Write never high, word 0x20 still reads 0.
REQ-040 Byte store 0x55 at 0x10 with Reset = 0 during CAP -> no Mem_Write, no rsp_valid, req_ready = 1; word 0x10 still reads 0xDEADAAEF.
REQ-041 req_valid held high with two back-to-back loads -> req_ready low from RD through RESP; second request accepted on the edge after RESP; no request is lost or duplicated.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// CPU-side load/store controller for a 32-bit little-endian data memory with byte/halfword
// access, sign/zero extension and read-modify-write for sub-word stores.
module mem_access_ctrl (
   input  logic        CLK,
   input  logic        Reset,
   input  logic        req_valid,
   output logic        req_ready,
   input  logic        req_we,
   input  logic [1:0]  req_size,
   input  logic        req_signed,
   input  logic [7:0]  req_addr,
   input  logic [31:0] req_wdata,
   output logic        rsp_valid,
   output logic [31:0] rsp_rdata,
   output logic        rsp_err,
   output logic [7:0]  Mem_Addr,
   output logic        Mem_Read,
   output logic        Mem_Write,
   output logic [31:0] M_W_Data,
   input  logic [31:0] M_R_Data
);

   typedef enum logic [2:0] {IDLE, RD, CAP, WR, RESP} state_t;

   state_t      state;
   logic        we_q;
   logic        signed_q;
   logic [1:0]  size_q;
   logic [1:0]  lane_q;
   logic [7:0]  addr_q;
   logic [31:0] wdata_q;
   logic [31:0] merge_q;
   logic        accept;
   logic        req_bad;

   function automatic logic is_illegal(input logic [1:0] size, input logic [1:0] lane);
      case (size)
         2'b00:   is_illegal = 1'b0;
         2'b01:   is_illegal = lane[0];
         2'b10:   is_illegal = (lane != 2'b00);
         default: is_illegal = 1'b1;
      endcase
   endfunction

   function automatic logic [31:0] extend_lane(input logic [31:0] word, input logic [1:0] size,
                                               input logic [1:0] lane, input logic sgn);
      logic [7:0]  b;
      logic [15:0] h;
      b = word[{lane, 3'b000} +: 8];
      h = lane[1] ? word[31:16] : word[15:0];
      case (size)
         2'b00:   extend_lane = {{24{sgn & b[7]}}, b};
         2'b01:   extend_lane = {{16{sgn & h[15]}}, h};
         default: extend_lane = word;
      endcase
   endfunction

   function automatic logic [31:0] merge_lane(input logic [31:0] word, input logic [15:0] low,
                                              input logic [1:0] size, input logic [1:0] lane);
      logic [31:0] m;
      m = word;
      if (size == 2'b00)
         m[{lane, 3'b000} +: 8] = low[7:0];
      else if (lane[1])
         m[31:16] = low;
      else
         m[15:0] = low;
      merge_lane = m;
   endfunction

   assign accept  = req_valid && req_ready;
   assign req_bad = is_illegal(req_size, req_addr[1:0]);

   // Request fields only matter while a transaction is in flight, so they carry no reset.
   always_ff @(posedge CLK) begin
      if (accept) begin
         we_q     <= req_we;
         signed_q <= req_signed;
         size_q   <= req_size;
         lane_q   <= req_addr[1:0];
         addr_q   <= {req_addr[7:2], 2'b00};
         wdata_q  <= req_wdata;
      end
      if (state == CAP)
         merge_q <= merge_lane(M_R_Data, wdata_q[15:0], size_q, lane_q);
   end

   always_ff @(posedge CLK or negedge Reset) begin
      if (!Reset) begin
         state     <= IDLE;
         rsp_rdata <= '0;
         rsp_err   <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (req_valid) begin
                  rsp_rdata <= '0;
                  rsp_err   <= req_bad;
                  if (req_bad)
                     state <= RESP;
                  else if (req_we && req_size == 2'b10)
                     state <= WR;
                  else
                     state <= RD;
               end
            end
            RD:   state <= CAP;
            CAP: begin
               // Loads finish here; sub-word stores go on to write the merged word.
               if (we_q) begin
                  state <= WR;
               end else begin
                  rsp_rdata <= extend_lane(M_R_Data, size_q, lane_q, signed_q);
                  state     <= RESP;
               end
            end
            WR:      state <= RESP;
            RESP:    state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

   assign req_ready = (state == IDLE);
   assign rsp_valid = (state == RESP);
   assign Mem_Read  = (state == RD);
   assign Mem_Write = (state == WR);
   assign Mem_Addr  = (state == RD || state == WR) ? addr_q : 8'h00;
   assign M_W_Data  = (state == WR) ? ((size_q == 2'b10) ? wdata_q : merge_q) : 32'h0;

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Bench for mem_access_ctrl: registered data memory, transaction-level reference model
// checked every cycle, directed scenarios with literal expectations, then random traffic.
module tb_mem_access_ctrl;

   logic        CLK = 1'b0;
   logic        Reset = 1'b0;
   logic        req_valid = 1'b0;
   logic        req_ready;
   logic        req_we = 1'b0;
   logic [1:0]  req_size = 2'b00;
   logic        req_signed = 1'b0;
   logic [7:0]  req_addr = 8'h00;
   logic [31:0] req_wdata = 32'h0;
   logic        rsp_valid;
   logic [31:0] rsp_rdata;
   logic        rsp_err;
   logic [7:0]  Mem_Addr;
   logic        Mem_Read;
   logic        Mem_Write;
   logic [31:0] M_W_Data;
   logic [31:0] M_R_Data;

   always #5 CLK = ~CLK;

   mem_access_ctrl dut (
      .CLK        (CLK),
      .Reset      (Reset),
      .req_valid  (req_valid),
      .req_ready  (req_ready),
      .req_we     (req_we),
      .req_size   (req_size),
      .req_signed (req_signed),
      .req_addr   (req_addr),
      .req_wdata  (req_wdata),
      .rsp_valid  (rsp_valid),
      .rsp_rdata  (rsp_rdata),
      .rsp_err    (rsp_err),
      .Mem_Addr   (Mem_Addr),
      .Mem_Read   (Mem_Read),
      .Mem_Write  (Mem_Write),
      .M_W_Data   (M_W_Data),
      .M_R_Data   (M_R_Data)
   );

   // Data memory seen by the DUT: read word registered, valid the cycle after Mem_Read.
   logic [31:0] mem [64] = '{default: 32'h0};
   logic [31:0] rd_q = 32'h0;
   always @(posedge CLK) begin
      if (Mem_Read)  rd_q <= mem[Mem_Addr[7:2]];
      if (Mem_Write) mem[Mem_Addr[7:2]] <= M_W_Data;
   end
   assign M_R_Data = rd_q;

   int total = 0;
   int bad = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h, expected %h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one transaction at a time, described by its latency and by what it
   // must do to memory and to the response, rather than by controller states.
   logic [31:0] ref_mem [64] = '{default: 32'h0};
   int          k = 0;
   int          lat = 0;
   logic        m_err = 1'b0;
   logic        m_we = 1'b0;
   logic [7:0]  m_aligned = 8'h00;
   logic [31:0] m_wexp = 32'h0;
   logic [31:0] m_rexp = 32'h0;
   logic [31:0] held_rdata = 32'h0;
   logic        held_err = 1'b0;
   logic        e_rd, e_wr, e_resp;

   task automatic predict();
      logic [31:0] w, v, mask;
      int sh;
      m_err = (req_size == 2'b11) || (req_size == 2'b01 && req_addr[0]) ||
              (req_size == 2'b10 && req_addr[1:0] != 2'b00);
      m_we      = req_we;
      m_aligned = req_addr & 8'hFC;
      w         = ref_mem[req_addr[7:2]];
      sh        = 8 * int'(req_addr[1:0]);
      m_wexp    = 32'h0;
      m_rexp    = 32'h0;
      if (m_err) begin
         lat = 1;
      end else if (req_we && req_size == 2'b10) begin
         lat = 2;
         m_wexp = req_wdata;
      end else if (!req_we) begin
         lat = 3;
         case (req_size)
            2'b00: begin
               v = (w >> sh) & 32'hFF;
               if (req_signed && v >= 32'h80) v = v | 32'hFFFFFF00;
            end
            2'b01: begin
               v = (w >> sh) & 32'hFFFF;
               if (req_signed && v >= 32'h8000) v = v | 32'hFFFF0000;
            end
            default: v = w;
         endcase
         m_rexp = v;
      end else begin
         lat = 4;
         mask = (req_size == 2'b00) ? 32'hFF : 32'hFFFF;
         m_wexp = (w & ~(mask << sh)) | ((req_wdata & mask) << sh);
      end
   endtask

   always @(posedge CLK) begin
      if (!Reset) begin
         k = 0;
         held_rdata = 32'h0;
         held_err = 1'b0;
      end else if (k != 0) begin
         if (m_we && !m_err && k == lat - 1) ref_mem[m_aligned[7:2]] = m_wexp;
         if (k == lat) begin
            k = 0;
         end else begin
            k++;
            if (k == lat) begin
               held_rdata = m_rexp;
               held_err = m_err;
            end
         end
      end else if (req_valid) begin
         predict();
         k = 1;
         held_rdata = 32'h0;
         held_err = 1'b0;
         if (k == lat) begin
            held_rdata = m_rexp;
            held_err = m_err;
         end
      end
      #2;
      e_resp = (k != 0 && k == lat);
      e_rd   = (k == 1 && lat >= 3);
      e_wr   = (m_we && !m_err && k != 0 && k == lat - 1);
      chk("req_ready", 32'(req_ready), 32'(k == 0));
      chk("rsp_valid", 32'(rsp_valid), 32'(e_resp));
      chk("mem_read",  32'(Mem_Read),  32'(e_rd));
      chk("mem_write", 32'(Mem_Write), 32'(e_wr));
      chk("mem_addr",  32'(Mem_Addr),  (e_rd || e_wr) ? 32'(m_aligned) : 32'h0);
      chk("m_w_data",  M_W_Data,       e_wr ? m_wexp : 32'h0);
      if (k == 0 || e_resp) begin
         chk("rsp_rdata", rsp_rdata, held_rdata);
         chk("rsp_err",   32'(rsp_err), 32'(held_err));
      end
   end

   // Issue one request starting at a negedge; returns at the negedge of its response.
   task automatic xact(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [7:0] addr, input logic [31:0] wdata,
                       output int lt, output logic [31:0] rdata, output logic err,
                       output int nwr, output int nstb, output logic [31:0] wd);
      int guard;
      req_we = we; req_size = size; req_signed = sgn; req_addr = addr; req_wdata = wdata;
      req_valid = 1'b1;
      lt = 0; rdata = 32'h0; err = 1'b0; nwr = 0; nstb = 0; wd = 32'h0;
      guard = 0;
      while (!req_ready && guard < 20) begin
         @(negedge CLK);
         guard++;
      end
      if (!req_ready) begin
         chk("accept_timeout", 32'(req_ready), 32'h1);
         req_valid = 1'b0;
         return;
      end
      @(negedge CLK);
      req_valid  = 1'b0;
      req_addr   = 8'($urandom);
      req_wdata  = $urandom;
      req_size   = 2'($urandom);
      req_we     = 1'($urandom);
      req_signed = 1'($urandom);
      for (int c = 1; c <= 12; c++) begin
         if (Mem_Write) begin
            nwr++;
            wd = M_W_Data;
         end
         if (Mem_Read || Mem_Write) nstb++;
         if (rsp_valid) begin
            lt = c;
            rdata = rsp_rdata;
            err = rsp_err;
            break;
         end
         @(negedge CLK);
      end
      chk("rsp_timeout", 32'(rsp_valid), 32'h1);
   endtask

   initial begin
      int lt, nwr, nstb, nv, nlow;
      logic [31:0] rd, wd;
      logic [31:0] r [2];
      logic er, prev_rdy;

      repeat (3) @(negedge CLK);
      chk("rst_ready",     32'(req_ready), 32'h1);
      chk("rst_rsp_valid", 32'(rsp_valid), 32'h0);
      chk("rst_mem_read",  32'(Mem_Read),  32'h0);
      chk("rst_mem_write", 32'(Mem_Write), 32'h0);
      chk("rst_mem_addr",  32'(Mem_Addr),  32'h0);
      chk("rst_m_w_data",  M_W_Data,       32'h0);
      chk("rst_rsp_rdata", rsp_rdata,      32'h0);
      chk("rst_rsp_err",   32'(rsp_err),   32'h0);

      Reset = 1'b1;
      xact(1'b1, 2'b10, 1'b0, 8'h10, 32'hDEADBEEF, lt, rd, er, nwr, nstb, wd);
      chk("sw_lat", lt, 2);
      chk("sw_nwr", nwr, 1);
      chk("sw_data", wd, 32'hDEADBEEF);
      xact(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("lw_lat", lt, 3);
      chk("lw_data", rd, 32'hDEADBEEF);
      chk("lw_nwr", nwr, 0);

      xact(1'b1, 2'b00, 1'b0, 8'h11, 32'h000000AA, lt, rd, er, nwr, nstb, wd);
      chk("sb_lat", lt, 4);
      chk("sb_merge", wd, 32'hDEADAAEF);
      chk("sb_rdata", rd, 32'h0);
      xact(1'b0, 2'b00, 1'b1, 8'h11, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("lb_signed", rd, 32'hFFFFFFAA);
      xact(1'b0, 2'b00, 1'b0, 8'h11, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("lb_unsigned", rd, 32'h000000AA);

      xact(1'b0, 2'b01, 1'b1, 8'h12, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("lh_signed", rd, 32'hFFFFDEAD);
      xact(1'b0, 2'b01, 1'b0, 8'h12, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("lh_unsigned", rd, 32'h0000DEAD);
      xact(1'b0, 2'b01, 1'b1, 8'h13, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("lh_mis_err", 32'(er), 32'h1);
      chk("lh_mis_lat", lt, 1);
      chk("lh_mis_strobes", nstb, 0);

      xact(1'b1, 2'b11, 1'b0, 8'h20, 32'h12345678, lt, rd, er, nwr, nstb, wd);
      chk("sz11_err", 32'(er), 32'h1);
      chk("sz11_nwr", nwr, 0);
      xact(1'b0, 2'b10, 1'b0, 8'h20, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("sz11_word", rd, 32'h0);
      chk("sz11_rd_err", 32'(er), 32'h0);

      // Reset during CAP of a byte store must leave memory untouched.
      @(negedge CLK);
      req_we = 1'b1; req_size = 2'b00; req_addr = 8'h10; req_wdata = 32'h55; req_signed = 1'b0;
      req_valid = 1'b1;
      @(negedge CLK);
      req_valid = 1'b0;
      @(negedge CLK);
      Reset = 1'b0;
      #1;
      chk("abort_ready", 32'(req_ready), 32'h1);
      chk("abort_valid", 32'(rsp_valid), 32'h0);
      chk("abort_write", 32'(Mem_Write), 32'h0);
      chk("abort_m_w_data", M_W_Data, 32'h0);
      nwr = 0; nv = 0;
      repeat (3) begin
         @(negedge CLK);
         if (Mem_Write) nwr++;
         if (rsp_valid) nv++;
      end
      Reset = 1'b1;
      repeat (5) begin
         @(negedge CLK);
         if (Mem_Write) nwr++;
         if (rsp_valid) nv++;
      end
      chk("abort_nwr", nwr, 0);
      chk("abort_nrsp", nv, 0);
      xact(1'b0, 2'b10, 1'b0, 8'h10, 32'h0, lt, rd, er, nwr, nstb, wd);
      chk("abort_word", rd, 32'hDEADAAEF);

      // Two loads with req_valid held high throughout.
      @(negedge CLK);
      req_we = 1'b0; req_size = 2'b10; req_addr = 8'h10; req_signed = 1'b0; req_valid = 1'b1;
      nv = 0; nlow = 0; prev_rdy = 1'b0;
      r[0] = 32'h0; r[1] = 32'h0;
      for (int c = 1; c <= 12; c++) begin
         @(negedge CLK);
         if (c == 1) begin
            req_size = 2'b00;
            req_addr = 8'h11;
         end
         if (c <= 3 && !req_ready) nlow++;
         if (rsp_valid) begin
            if (nv < 2) r[nv] = rsp_rdata;
            nv++;
         end
         if (prev_rdy && nv >= 1) req_valid = 1'b0;
         prev_rdy = req_ready;
      end
      chk("b2b_ready_low", nlow, 3);
      chk("b2b_count", nv, 2);
      chk("b2b_first", r[0], 32'hDEADAAEF);
      chk("b2b_second", r[1], 32'h000000AA);

      for (int i = 0; i < 3000; i++) begin
         @(negedge CLK);
         Reset      = ($urandom_range(0, 79) != 0);
         req_valid  = ($urandom_range(0, 3) != 0);
         req_we     = 1'($urandom);
         req_size   = 2'($urandom);
         req_signed = 1'($urandom);
         req_addr   = 8'($urandom_range(0, 63));
         req_wdata  = $urandom;
      end
      @(negedge CLK);
      Reset = 1'b1;
      req_valid = 1'b0;
      repeat (8) @(negedge CLK);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
